// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//
// Purpose:
//   Data-hazard and control-hazard unit for a 5-stage in-order pipeline
//   (IF / ID / EX / MEM / WB). It keeps a small shadow copy of the
//   destination-register information for the instructions in EX, MEM and WB.
//   From this copy it decides whether the instruction in ID must stall, be
//   flushed, or take operands from the bypass network.
//
// Configuration macro:
//   FORWARD_EN  - when defined, forwarding is enabled. The unit then stalls
//                 only on load-use, for one cycle, and drives fwd_a / fwd_b.
//                 When undefined, fwd_a / fwd_b are tied to 2'b00. The unit
//                 stalls while any of EX / MEM / WB still has to write a
//                 source register, because the register file is not
//                 write-through.
//
// Ports:
//   cpu_clk      in   1  sole clock, rising edge
//   cpu_rst      in   1  asynchronous reset, active-high
//   id_valid     in   1  ID holds a real instruction
//   id_rs1       in   5  first source register
//   id_rs2       in   5  second source register
//   id_rs1_used  in   1  instruction reads rs1
//   id_rs2_used  in   1  instruction reads rs2
//   id_rd        in   5  destination register
//   id_rf_we     in   1  instruction writes the register file
//   id_is_load   in   1  write data comes from RAM read data
//   ex_redirect  in   1  branch/jump resolved in EX, NPC takes target
//   pc_stall     out  1  hold PC
//   if_id_stall  out  1  hold the IF/ID register
//   if_id_flush  out  1  load a bubble into IF/ID
//   id_ex_flush  out  1  load a bubble into ID/EX
//   fwd_a        out  2  A-operand forward select
//                        (01 EX ALU_C, 10 MEM wD, 11 WB wD, 00 RF)
//   fwd_b        out  2  B-operand forward select (same encoding)
//   stall_cnt    out 16  saturating count of stall cycles
//   flush_cnt    out 16  saturating count of redirects
// ---------------------------------------------------------------------------
module hazard_ctrl (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic [4:0]  id_rd,
  input  logic        id_rf_we,
  input  logic        id_is_load,
  input  logic        ex_redirect,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  // Shadow stage indices: 0 is the youngest (EX), 2 the oldest (WB).
  localparam int NSTG   = 3;
  localparam int STG_EX = 0;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  // -------------------------------------------------------------------------
  // Shadow state
  // -------------------------------------------------------------------------
  logic [NSTG-1:0] sh_valid_reg;
  logic [NSTG-1:0] sh_we_reg;
  logic [NSTG-1:0] sh_load_reg;
  logic [4:0]      sh_rd_reg [NSTG];

  logic [15:0]     stall_cnt_reg;
  logic [15:0]     flush_cnt_reg;

  // Per-stage source matches.
  logic [NSTG-1:0] match_a;
  logic [NSTG-1:0] match_b;

  logic            data_hazard;
  logic [1:0]      fwd_a_next;
  logic [1:0]      fwd_b_next;
  logic            id_bubble;
  logic            ex_valid_next;

  // -------------------------------------------------------------------------
  // Source-register matching, one comparator pair per shadow stage.
  // Writes to x0 never create a dependency.
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NSTG; gi++) begin : g_match
      logic stage_writes;
      assign stage_writes = sh_valid_reg[gi] & sh_we_reg[gi] &
                            (sh_rd_reg[gi] != 5'd0);
      assign match_a[gi]  = id_valid & id_rs1_used & stage_writes &
                            (sh_rd_reg[gi] == id_rs1);
      assign match_b[gi]  = id_valid & id_rs2_used & stage_writes &
                            (sh_rd_reg[gi] == id_rs2);
    end
  endgenerate

`ifdef FORWARD_EN
  // Youngest producer wins: EX, then MEM, then WB, else register file.
  function automatic logic [1:0] fwd_select(input logic [NSTG-1:0] m);
    logic [1:0] sel;
    sel = 2'b00;
    if (m[0])      sel = 2'b01;
    else if (m[1]) sel = 2'b10;
    else if (m[2]) sel = 2'b11;
    return sel;
  endfunction

  // With a bypass network, only a load still in EX cannot supply its data
  // in time. Its RAM read data first exists in MEM, so one stall is enough.
  assign data_hazard = sh_load_reg[STG_EX] &
                       (match_a[STG_EX] | match_b[STG_EX]);
  assign fwd_a_next  = fwd_select(match_a);
  assign fwd_b_next  = fwd_select(match_b);

  // The load flag is only consulted in EX. The older copies exist so that
  // each shadow entry carries the full {valid, rd, we, load} record.
  logic unused_load_bits;
  assign unused_load_bits = ^sh_load_reg[NSTG-1:1];
`else
  // Without bypassing, the operand is readable from the register file only
  // after the producer has left WB. This allows up to three stall cycles.
  assign data_hazard = (|match_a) | (|match_b);
  assign fwd_a_next  = 2'b00;
  assign fwd_b_next  = 2'b00;

  logic unused_load_bits;
  assign unused_load_bits = ^sh_load_reg;
`endif

  // -------------------------------------------------------------------------
  // Hazard outputs (combinational, zero latency).
  // A redirect overrides any data stall. The instruction that wanted to
  // stall is on the wrong path and is flushed anyway. Nothing is asserted
  // while reset is active or when ID holds no instruction.
  // -------------------------------------------------------------------------
  always_comb begin
    pc_stall    = 1'b0;
    if_id_stall = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    fwd_a       = 2'b00;
    fwd_b       = 2'b00;
    if (!cpu_rst) begin
      fwd_a = fwd_a_next;
      fwd_b = fwd_b_next;
      if (id_valid) begin
        if (ex_redirect) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (data_hazard) begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_flush = 1'b1;
        end
      end
    end
  end

  // ID enters EX as a bubble while stalled or when it is on a squashed path.
  assign id_bubble     = pc_stall | ex_redirect;
  assign ex_valid_next = id_valid & ~id_bubble;

  // -------------------------------------------------------------------------
  // Shadow pipeline: EX takes the ID fields, older stages shift by one.
  // Reset clears everything, so a stall in progress ends at once and no
  // stale producer survives into the next instruction stream.
  // -------------------------------------------------------------------------
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      sh_valid_reg[STG_EX] <= 1'b0;
      sh_we_reg[STG_EX]    <= 1'b0;
      sh_load_reg[STG_EX]  <= 1'b0;
      sh_rd_reg[STG_EX]    <= 5'd0;
    end else begin
      sh_valid_reg[STG_EX] <= ex_valid_next;
      sh_we_reg[STG_EX]    <= id_rf_we;
      sh_load_reg[STG_EX]  <= id_is_load;
      sh_rd_reg[STG_EX]    <= id_rd;
    end
  end

  generate
    for (genvar gi = 1; gi < NSTG; gi++) begin : g_shift
      always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
          sh_valid_reg[gi] <= 1'b0;
          sh_we_reg[gi]    <= 1'b0;
          sh_load_reg[gi]  <= 1'b0;
          sh_rd_reg[gi]    <= 5'd0;
        end else begin
          sh_valid_reg[gi] <= sh_valid_reg[gi-1];
          sh_we_reg[gi]    <= sh_we_reg[gi-1];
          sh_load_reg[gi]  <= sh_load_reg[gi-1];
          sh_rd_reg[gi]    <= sh_rd_reg[gi-1];
        end
      end
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Saturating event counters.
  // -------------------------------------------------------------------------
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      stall_cnt_reg <= 16'd0;
      flush_cnt_reg <= 16'd0;
    end else begin
      if (pc_stall && (stall_cnt_reg != CNT_MAX))
        stall_cnt_reg <= stall_cnt_reg + 16'd1;
      if (if_id_flush && (flush_cnt_reg != CNT_MAX))
        flush_cnt_reg <= flush_cnt_reg + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Self-checking bench for hazard_ctrl. It keeps a reference model: a list of
// the last three instructions that entered EX, plus two integer counters.
// The model is checked against the DUT on every falling edge. Directed
// sequences with literal expectations pin down the model. A randomized
// phase then exercises arbitrary mixes of dependencies, loads and
// redirects. Build with +define+FORWARD_EN to check the forwarding
// configuration.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst = 1'b1;
  logic        id_valid = 1'b0;
  logic [4:0]  id_rs1 = 5'd0;
  logic [4:0]  id_rs2 = 5'd0;
  logic        id_rs1_used = 1'b0;
  logic        id_rs2_used = 1'b0;
  logic [4:0]  id_rd = 5'd0;
  logic        id_rf_we = 1'b0;
  logic        id_is_load = 1'b0;
  logic        ex_redirect = 1'b0;
  logic        pc_stall, if_id_stall, if_id_flush, id_ex_flush;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cnt, flush_cnt;

  hazard_ctrl dut (
    .cpu_clk     (cpu_clk),
    .cpu_rst     (cpu_rst),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .id_rd       (id_rd),
    .id_rf_we    (id_rf_we),
    .id_is_load  (id_is_load),
    .ex_redirect (ex_redirect),
    .pc_stall    (pc_stall),
    .if_id_stall (if_id_stall),
    .if_id_flush (if_id_flush),
    .id_ex_flush (id_ex_flush),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  always #5 cpu_clk = ~cpu_clk;

  int checks = 0;
  int errors = 0;
  bit verbose = 1'b1;

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model: the instructions that issued into EX, youngest first.
  // -------------------------------------------------------------------------
  typedef struct packed {
    bit       v;
    bit [4:0] rd;
    bit       we;
    bit       ld;
  } instr_t;

  instr_t hist [3];
  int     m_stall_cnt = 0;
  int     m_flush_cnt = 0;

  // True when the older instruction 'p' produces the value ID needs.
  function automatic bit dep(instr_t p, bit [4:0] rs, bit used);
    return id_valid && used && p.v && p.we && (p.rd != 5'd0) && (p.rd == rs);
  endfunction

  function automatic void model_out(output bit ps, output bit iis,
                                    output bit iif, output bit ief,
                                    output bit [1:0] fa, output bit [1:0] fb);
    bit hz;
    ps = 0; iis = 0; iif = 0; ief = 0; fa = 2'b00; fb = 2'b00;
    if (cpu_rst) return;
    hz = 0;
`ifdef FORWARD_EN
    // Scan oldest to youngest so the youngest producer overwrites the rest.
    for (int k = 2; k >= 0; k--) begin
      if (dep(hist[k], id_rs1, id_rs1_used)) fa = 2'(k + 1);
      if (dep(hist[k], id_rs2, id_rs2_used)) fb = 2'(k + 1);
    end
    hz = hist[0].ld && (dep(hist[0], id_rs1, id_rs1_used) ||
                        dep(hist[0], id_rs2, id_rs2_used));
`else
    for (int k = 0; k < 3; k++)
      if (dep(hist[k], id_rs1, id_rs1_used) || dep(hist[k], id_rs2, id_rs2_used))
        hz = 1;
`endif
    if (id_valid && ex_redirect) begin
      iif = 1; ief = 1;
    end else if (id_valid && hz) begin
      ps = 1; iis = 1; ief = 1;
    end
  endfunction

  always @(posedge cpu_clk or posedge cpu_rst) begin
    bit ps, iis, iif, ief;
    bit [1:0] fa, fb;
    if (cpu_rst) begin
      for (int k = 0; k < 3; k++) hist[k] = '0;
      m_stall_cnt = 0;
      m_flush_cnt = 0;
    end else begin
      model_out(ps, iis, iif, ief, fa, fb);
      if (ps  && m_stall_cnt < 65535) m_stall_cnt++;
      if (iif && m_flush_cnt < 65535) m_flush_cnt++;
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = '{v: id_valid && !ps && !ex_redirect, rd: id_rd,
                  we: id_rf_we, ld: id_is_load};
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge cpu_clk) begin
    bit ps, iis, iif, ief;
    bit [1:0] fa, fb;
    model_out(ps, iis, iif, ief, fa, fb);
    check("pc_stall",    {15'd0, pc_stall},    {15'd0, ps});
    check("if_id_stall", {15'd0, if_id_stall}, {15'd0, iis});
    check("if_id_flush", {15'd0, if_id_flush}, {15'd0, iif});
    check("id_ex_flush", {15'd0, id_ex_flush}, {15'd0, ief});
    check("fwd_a",       {14'd0, fwd_a},       {14'd0, fa});
    check("fwd_b",       {14'd0, fwd_b},       {14'd0, fb});
    check("stall_cnt",   stall_cnt,            16'(m_stall_cnt));
    check("flush_cnt",   flush_cnt,            16'(m_flush_cnt));
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers
  // -------------------------------------------------------------------------
  task automatic set_id(input bit v, input bit [4:0] rs1, input bit u1,
                        input bit [4:0] rs2, input bit u2, input bit [4:0] rd,
                        input bit we, input bit ld, input bit redir);
    id_valid = v; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2;
    id_rs2_used = u2; id_rd = rd; id_rf_we = we; id_is_load = ld;
    ex_redirect = redir;
    if (verbose)
      $display("txn t=%0t v=%0d rs1=%0d/%0d rs2=%0d/%0d rd=%0d we=%0d ld=%0d redir=%0d",
               $time, v, rs1, u1, rs2, u2, rd, we, ld, redir);
  endtask

  task automatic step();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge cpu_clk);
    #1;
  endtask

  logic [15:0] base_stall, base_flush;

  initial begin
    // Reset held with an active redirect: nothing may be asserted.
    set_id(1, 5'd1, 1, 5'd2, 1, 5'd1, 1, 0, 1);
    at_neg();
    check("rst_if_id_flush", {15'd0, if_id_flush}, 16'd0);
    check("rst_stall_cnt", stall_cnt, 16'd0);
    step();
    cpu_rst = 1'b0;

    // Ten hazard-free instructions.
    for (int i = 0; i < 10; i++) begin
      set_id(1, 5'd1, 1, 5'd2, 1, 5'd3, 0, 0, 0);
      at_neg();
      check("idle_pc_stall", {15'd0, pc_stall}, 16'd0);
      check("idle_flush", {14'd0, if_id_flush, id_ex_flush}, 16'd0);
      step();
    end
    check("idle_stall_cnt", stall_cnt, 16'd0);
    check("idle_flush_cnt", flush_cnt, 16'd0);

`ifdef FORWARD_EN
    // add x5, then two readers of x5: EX bypass, then MEM bypass.
    set_id(1, 5'd1, 0, 5'd2, 0, 5'd5, 1, 0, 0);
    step();
    set_id(1, 5'd5, 1, 5'd2, 0, 5'd8, 1, 0, 0);
    at_neg();
    check("fwd_ex_fwd_a", {14'd0, fwd_a}, 16'd1);
    check("fwd_ex_stall", {15'd0, pc_stall}, 16'd0);
    step();
    set_id(1, 5'd5, 1, 5'd2, 0, 5'd9, 1, 0, 0);
    at_neg();
    check("fwd_mem_fwd_a", {14'd0, fwd_a}, 16'd2);
    step();

    // lw x6, then add reading x6 through rs2: exactly one stall.
    base_stall = stall_cnt;
    set_id(1, 5'd1, 0, 5'd2, 0, 5'd6, 1, 1, 0);
    step();
    set_id(1, 5'd1, 0, 5'd6, 1, 5'd10, 1, 0, 0);
    at_neg();
    check("lu_pc_stall", {15'd0, pc_stall}, 16'd1);
    check("lu_id_ex_flush", {15'd0, id_ex_flush}, 16'd1);
    step();
    at_neg();
    check("lu_release_stall", {15'd0, pc_stall}, 16'd0);
    check("lu_fwd_b", {14'd0, fwd_b}, 16'd2);
    step();
    check("lu_stall_cnt", stall_cnt, base_stall + 16'd1);
`else
    // add x7, then a reader of x7: three stalls, then released.
    base_stall = stall_cnt;
    set_id(1, 5'd1, 0, 5'd2, 0, 5'd7, 1, 0, 0);
    step();
    set_id(1, 5'd7, 1, 5'd2, 0, 5'd11, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      at_neg();
      check($sformatf("nf_pc_stall_%0d", i), {15'd0, pc_stall},
            (i < 3) ? 16'd1 : 16'd0);
      check($sformatf("nf_fwd_a_%0d", i), {14'd0, fwd_a}, 16'd0);
      step();
    end
    check("nf_stall_cnt", stall_cnt, base_stall + 16'd3);
`endif

    // Redirect in the same cycle as a load-use hazard.
    set_id(1, 5'd1, 0, 5'd2, 0, 5'd0, 0, 0, 0);
    repeat (3) step();
    base_stall = stall_cnt;
    base_flush = flush_cnt;
    set_id(1, 5'd1, 0, 5'd2, 0, 5'd12, 1, 1, 0);
    step();
    set_id(1, 5'd12, 1, 5'd2, 0, 5'd13, 1, 0, 1);
    at_neg();
    check("rd_pc_stall", {15'd0, pc_stall}, 16'd0);
    check("rd_if_id_stall", {15'd0, if_id_stall}, 16'd0);
    check("rd_if_id_flush", {15'd0, if_id_flush}, 16'd1);
    check("rd_id_ex_flush", {15'd0, id_ex_flush}, 16'd1);
    step();
    check("rd_flush_cnt", flush_cnt, base_flush + 16'd1);
    check("rd_stall_cnt", stall_cnt, base_stall);
    set_id(1, 5'd1, 0, 5'd2, 0, 5'd0, 0, 0, 0);
    repeat (3) step();

    // Load to x0 followed by a reader of x0: never a dependency.
    set_id(1, 5'd1, 0, 5'd2, 0, 5'd0, 1, 1, 0);
    step();
    set_id(1, 5'd0, 1, 5'd0, 1, 5'd14, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      at_neg();
      check("x0_pc_stall", {15'd0, pc_stall}, 16'd0);
      check("x0_fwd", {12'd0, fwd_a, fwd_b}, 16'd0);
      step();
    end

    // Reset pulsed in the middle of a load-use stall.
    set_id(1, 5'd1, 0, 5'd2, 0, 5'd7, 1, 1, 0);
    step();
    set_id(1, 5'd7, 1, 5'd2, 0, 5'd15, 1, 0, 0);
    at_neg();
    check("mid_stall_before_rst", {15'd0, pc_stall}, 16'd1);
    cpu_rst = 1'b1;
    #1;
    check("mid_rst_pc_stall", {15'd0, pc_stall}, 16'd0);
    check("mid_rst_id_ex_flush", {15'd0, id_ex_flush}, 16'd0);
    check("mid_rst_stall_cnt", stall_cnt, 16'd0);
    check("mid_rst_flush_cnt", flush_cnt, 16'd0);
    step();
    step();
    cpu_rst = 1'b0;
    at_neg();
    check("post_rst_pc_stall", {15'd0, pc_stall}, 16'd0);
    check("post_rst_fwd_a", {14'd0, fwd_a}, 16'd0);
    check("post_rst_stall_cnt", stall_cnt, 16'd0);
    check("post_rst_flush_cnt", flush_cnt, 16'd0);
    step();

    // Randomized traffic over a small register window to provoke hazards.
    verbose = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      set_id($urandom_range(0, 7) != 0,
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 2) == 0), $urandom_range(0, 9) == 0);
      step();
    end
    set_id(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0);
    at_neg();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
